// File: rtl/ct_lsu_spsram_pkg.sv
// Shared constants and helpers for the LSU single-port SRAM request sequencer.
package ct_lsu_spsram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One active-high byte enable becomes eight active-low bit write enables.
  function automatic logic [7:0] be_to_wen_byte(input logic be);
    return {8{~be}};
  endfunction

endpackage

// File: rtl/ct_lsu_spsram_rsp_fifo.sv
// Two-entry in-order response buffer; the caller guarantees it never pushes when full.
module ct_lsu_spsram_rsp_fifo
  import ct_lsu_spsram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_vld
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop = i_pop & (r_count != 2'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: data storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_vld   = (r_count != 2'd0);

endmodule

// File: rtl/ct_lsu_spsram_ctrl.sv
// Request sequencer for the LSU single-port SRAM: zero-fill sweep, then one access per cycle
// with read data returned through a credit-controlled two-entry response buffer.
module ct_lsu_spsram_ctrl
  import ct_lsu_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    init_done,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int         BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [0:0] ST_RESET  = INIT_EN ? ST_INIT : ST_RUN;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_rd_pend;

  logic                  w_init_act;
  logic                  w_run;
  logic                  w_pop;
  logic [1:0]            w_rsp_cnt;
  logic [2:0]            w_occ;
  logic                  w_rd_ok;
  logic                  w_acc_rd;
  logic                  w_acc_wr;
  logic [DATA_WIDTH-1:0] w_be_wen;

  // Reset is folded into the state decode so the SRAM sees idle controls while it is held.
  assign w_init_act = (r_state == ST_INIT) & ~cpurst;
  assign w_run      = (r_state == ST_RUN)  & ~cpurst;
  assign init_done  = (r_state == ST_RUN);

  assign w_pop = rsp_vld & rsp_rdy;

  // Slots already spoken for: buffered + in flight, minus the one leaving this cycle.
  assign w_occ   = {1'b0, w_rsp_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd_ok = (w_occ < 3'd2);

  assign req_rdy  = w_run & (req_wr | w_rd_ok);
  assign w_acc_rd = req_vld & req_rdy & ~req_wr;
  assign w_acc_wr = req_vld & req_rdy &  req_wr;

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_wen
    assign w_be_wen[8*i +: 8] = be_to_wen_byte(req_be[i]);
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = req_addr;
    sram_d    = req_wdata;
    if (w_init_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_init_cnt;
      sram_d    = '0;
    end else if (w_acc_rd) begin
      sram_cen  = 1'b0;
    end else if (w_acc_wr) begin
      sram_cen  = ~|req_be;
      sram_gwen = 1'b0;
      sram_wen  = w_be_wen;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= ST_RESET;
      r_init_cnt <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == '1) r_state <= ST_RUN;
      end
      r_rd_pend <= w_acc_rd;
    end
  end

  // sram_q belongs to the read issued last cycle and is captured at the end of this one.
  ct_lsu_spsram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .i_clk       (forever_cpuclk),
    .i_rst       (cpurst),
    .i_push      (r_rd_pend),
    .i_push_data (sram_q),
    .i_pop       (w_pop),
    .o_count     (w_rsp_cnt),
    .o_head      (rsp_data),
    .o_vld       (rsp_vld)
  );

endmodule

// File: tb/tb_ct_lsu_spsram_ctrl.sv
// Scoreboard bench for ct_lsu_spsram_ctrl with a behavioural 1024x32 SRAM behind it.
module tb_ct_lsu_spsram_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        init_done;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [9:0]  sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  always #5 clk = ~clk;

  ct_lsu_spsram_ctrl #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .INIT_EN    (1'b1)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_data       (rsp_data),
    .init_done      (init_done),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural SRAM: bit-masked writes, read data one cycle after the access.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  logic [31:0] next_exp;
  logic        last_cen;
  logic [31:0] last_wen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake, push expectations on read accepts.
  always @(negedge clk) begin
    if (rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got 0x%08h expected no response", rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_q.pop_front());
      end
      pop_cyc.push_back(cyc);
    end
    if (req_vld && req_rdy && !req_wr) exp_q.push_back(next_exp);
    check("fifo_count_le2", 32'(dut.w_rsp_cnt <= 2'd2), 32'd1);
    check("no_push_when_full", 32'(dut.r_rd_pend && (dut.w_rsp_cnt == 2'd2)), 32'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle();
    req_vld = 1'b0;
    req_wr  = 1'b0;
  endtask

  // Present one request from posedge+1 until accepted; returns at posedge+1 after the accept edge.
  task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] exp, output int acc_cyc);
    int waited = 0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_be = be;
    next_exp = exp;
    @(negedge clk);
    while (!req_rdy && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: addr 0x%03h never accepted, required accept within 20 cycles", addr);
      req_vld = 1'b0;
      acc_cyc = -1;
    end else begin
      acc_cyc  = cyc;
      last_cen = sram_cen;
      last_wen = sram_wen;
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 right after reset release; checks 1024 sweep cycles then init_done.
  task automatic sweep_check(input string tag);
    int          bad = 0;
    logic [9:0]  a_first = '1;
    logic [9:0]  kk;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      kk = k[9:0];
      if (k == 0) a_first = sram_a;
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 || sram_a !== kk ||
          sram_d !== 32'h0 || req_rdy !== 1'b0 || init_done !== 1'b0 || rsp_vld !== 1'b0)
        bad++;
    end
    check({tag, "_first_addr"}, 32'(a_first), 32'h0);
    check({tag, "_bad_cycles"}, 32'(bad), 32'h0);
    @(negedge clk);
    check({tag, "_init_done"}, 32'(init_done), 32'h1);
    check({tag, "_cen_idle"}, 32'(sram_cen), 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c, c0, c7, acc;
    logic [9:0] addr;

    cpurst = 1'b1; rsp_rdy = 1'b1;
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    next_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy",   32'(req_rdy),   32'h0);
    check("rst_cen",       32'(sram_cen),  32'h1);
    check("rst_gwen",      32'(sram_gwen), 32'h1);
    check("rst_wen",       sram_wen,       32'hFFFF_FFFF);
    check("rst_rsp_vld",   32'(rsp_vld),   32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    @(posedge clk); #1;
    cpurst = 1'b0;
    sweep_check("sweep1");

    // Top address after the sweep reads back zero two cycles after the accept.
    issue(1'b0, 10'h3FF, 32'h0, 4'h0, 32'h0, c);
    idle();
    @(negedge clk);
    check("rd3ff_vld_n1", 32'(rsp_vld), 32'h0);
    @(negedge clk);
    check("rd3ff_vld_n2", 32'(rsp_vld), 32'h1);
    @(posedge clk); #1;

    // Byte-masked merge, read the following cycle, then a write with no bytes enabled.
    issue(1'b1, 10'h2A5, 32'h1122_3344, 4'hF, 32'h0, c);
    issue(1'b1, 10'h2A5, 32'hDEAD_BEEF, 4'b0101, 32'h0, c);
    check("be0101_wen", last_wen, 32'hFF00_FF00);
    check("be0101_cen", 32'(last_cen), 32'h0);
    issue(1'b0, 10'h2A5, 32'h0, 4'h0, 32'h11AD_33EF, c);
    issue(1'b1, 10'h2A5, 32'hFFFF_FFFF, 4'h0, 32'h0, c);
    check("be0_cen", 32'(last_cen), 32'h1);
    issue(1'b0, 10'h2A5, 32'h0, 4'h0, 32'h11AD_33EF, c);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back reads with rsp_rdy high.
    for (int i = 0; i < 8; i++) issue(1'b1, 10'(i), 32'hC0DE_0000 + 32'(i), 4'hF, 32'h0, c);
    idle();
    pop_cyc.delete();
    c0 = 0; c7 = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 10'(i), 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i), c);
      if (i == 0) c0 = c;
      if (i == 7) c7 = c;
    end
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("b2b_accept_span", 32'(c7 - c0), 32'd7);
    check("b2b_rsp_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) check("b2b_rsp_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // Back-pressure: only two reads fit, writes still flow, draining restores credit.
    rsp_rdy = 1'b0;
    acc = 0; addr = 10'h0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = addr; next_exp = 32'hC0DE_0000;
    repeat (6) begin
      @(negedge clk);
      if (req_rdy) begin
        acc++;
        addr = addr + 10'h1;
      end
      @(posedge clk); #1;
      req_addr = addr;
      next_exp = 32'hC0DE_0000 + 32'(addr);
    end
    check("bp_reads_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp_read_blocked", 32'(req_rdy), 32'h0);
    check("bp_rsp_vld", 32'(rsp_vld), 32'h1);
    @(posedge clk); #1;
    req_wr = 1'b1; req_addr = 10'h100; req_wdata = 32'h5555_5555; req_be = 4'hF;
    @(negedge clk);
    check("bp_write_ready", 32'(req_rdy), 32'h1);
    @(posedge clk); #1;
    idle();
    rsp_rdy = 1'b1;
    c0 = cyc;
    issue(1'b0, 10'h100, 32'h0, 4'h0, 32'h5555_5555, c);
    check("bp_credit_restored", 32'(c - c0), 32'd0);
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with one response buffered and one read in flight.
    rsp_rdy = 1'b0;
    issue(1'b0, 10'h2, 32'h0, 4'h0, 32'hC0DE_0002, c);
    issue(1'b0, 10'h3, 32'h0, 4'h0, 32'hC0DE_0003, c);
    idle();
    check("mid_rsp_vld_before", 32'(rsp_vld), 32'h1);
    #1;
    cpurst = 1'b1;
    #1;
    check("mid_rsp_vld",   32'(rsp_vld),   32'h0);
    check("mid_init_done", 32'(init_done), 32'h0);
    check("mid_cen",       32'(sram_cen),  32'h1);
    check("mid_req_rdy",   32'(req_rdy),   32'h0);
    exp_q.delete();
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cpurst = 1'b0;
    sweep_check("sweep2");

    issue(1'b0, 10'h2A5, 32'h0, 4'h0, 32'h0, c);
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
